// File: rtl/echo_pkg.sv
// ============================================================================
//  Module      : echo_pkg
//  Description : Shared widths, sample/gain types and saturating add for the
//                echo feedback mixer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package echo_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int GAIN_WIDTH = 16;
    localparam int CLIP_CNT_W = 16;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic signed [GAIN_WIDTH-1:0] gain_t;
    // One bit of headroom: holds a scaled product (up to +2^(DW-1)) and dry+product.
    typedef logic signed [DATA_WIDTH:0]   wide_t;

    localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Half an LSB of the Q1.(GW-1) result, giving round-half-up before the shift.
    localparam logic signed [DATA_WIDTH+GAIN_WIDTH-1:0] ROUND_CONST =
        {{(DATA_WIDTH+1){1'b0}}, 1'b1, {(GAIN_WIDTH-2){1'b0}}};

    // Returns {clipped, saturated sum}.
    function automatic logic [DATA_WIDTH:0] sat_add(input sample_t a, input wide_t b);
        wide_t sum;
        sum = wide_t'(a) + b;
        if (sum > wide_t'(SAMPLE_MAX)) begin
            return {1'b1, SAMPLE_MAX};
        end else if (sum < wide_t'(SAMPLE_MIN)) begin
            return {1'b1, SAMPLE_MIN};
        end
        return {1'b0, sum[DATA_WIDTH-1:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/echo_gain_mul.sv
// ============================================================================
//  Module      : echo_gain_mul
//  Description : Registered signed sample x Q1.(GW-1) gain, rounded half-up
//                and scaled back to sample units with one bit of headroom.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module echo_gain_mul #(
    parameter int DATA_WIDTH = echo_pkg::DATA_WIDTH,
    parameter int GAIN_WIDTH = echo_pkg::GAIN_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic signed [GAIN_WIDTH-1:0] gain,
    output logic signed [DATA_WIDTH:0]   scaled
);
    import echo_pkg::*;

    localparam int c_PROD_W = DATA_WIDTH + GAIN_WIDTH;

    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_PROD_W-1:0] w_rounded;
    logic signed [DATA_WIDTH:0] r_scaled;

    assign w_prod    = sample * gain;
    assign w_rounded = w_prod + ROUND_CONST;

    // Dropping the low GW-1 bits is the arithmetic shift; -1.0 * -1.0 needs the extra top bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scaled <= '0;
        end else if (en) begin
            r_scaled <= w_rounded[c_PROD_W-1:GAIN_WIDTH-1];
        end
    end

    assign scaled = r_scaled;

endmodule

`default_nettype wire

// File: rtl/echo_feedback_mixer.sv
// ============================================================================
//  Module      : echo_feedback_mixer
//  Description : 3-stage feedback/wet mixer behind the circular delay buffer,
//                valid/ready on both sides, saturating clip-event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module echo_feedback_mixer #(
    parameter int DATA_WIDTH = echo_pkg::DATA_WIDTH,
    parameter int GAIN_WIDTH = echo_pkg::GAIN_WIDTH,
    parameter int CLIP_CNT_W = echo_pkg::CLIP_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] dry_in,
    input  logic                         dry_valid,
    output logic                         dry_ready,
    input  logic signed [DATA_WIDTH-1:0] delay_in,
    input  logic                         delay_valid,
    input  logic signed [GAIN_WIDTH-1:0] fb_gain,
    input  logic signed [GAIN_WIDTH-1:0] mix_gain,
    output logic signed [DATA_WIDTH-1:0] fb_out,
    output logic                         fb_wr_en,
    output logic signed [DATA_WIDTH-1:0] wet_out,
    output logic                         wet_valid,
    input  logic                         wet_ready,
    output logic [CLIP_CNT_W-1:0]        clip_count
);
    import echo_pkg::*;

    logic                         w_advance;
    logic                         w_s1_open;
    logic                         r_s1_valid;
    logic signed [DATA_WIDTH-1:0] r_s1_dry;
    logic signed [DATA_WIDTH-1:0] r_s1_delay;
    logic signed [GAIN_WIDTH-1:0] r_s1_fb_gain;
    logic signed [GAIN_WIDTH-1:0] r_s1_mix_gain;
    logic                         r_s2_valid;
    logic signed [DATA_WIDTH-1:0] r_s2_dry;
    logic signed [DATA_WIDTH:0]   w_s2_fb_scaled;
    logic signed [DATA_WIDTH:0]   w_s2_mix_scaled;
    logic [DATA_WIDTH:0]          w_fb_sat;
    logic [DATA_WIDTH:0]          w_wet_sat;
    logic signed [DATA_WIDTH-1:0] r_fb_out;
    logic signed [DATA_WIDTH-1:0] r_wet_out;
    logic                         r_fb_wr_en;
    logic                         r_wet_valid;
    logic [CLIP_CNT_W-1:0]        r_clip_count;

    assign w_advance = ~r_wet_valid | wet_ready;
    assign w_s1_open = ~r_s1_valid | w_advance;
    assign dry_ready = w_s1_open & ~rst;

    // An empty S1 may fill while S2/S3 are frozen; delay_in is captured only here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_dry      <= '0;
            r_s1_delay    <= '0;
            r_s1_fb_gain  <= '0;
            r_s1_mix_gain <= '0;
        end else if (w_s1_open) begin
            r_s1_valid <= dry_valid;
            if (dry_valid) begin
                r_s1_dry      <= dry_in;
                r_s1_delay    <= delay_valid ? delay_in : '0;
                r_s1_fb_gain  <= fb_gain;
                r_s1_mix_gain <= mix_gain;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_dry   <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            r_s2_dry   <= r_s1_dry;
        end
    end

    echo_gain_mul #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) u_fb_mul (
        .clk    (clk),
        .rst    (rst),
        .en     (w_advance),
        .sample (r_s1_delay),
        .gain   (r_s1_fb_gain),
        .scaled (w_s2_fb_scaled)
    );

    echo_gain_mul #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) u_mix_mul (
        .clk    (clk),
        .rst    (rst),
        .en     (w_advance),
        .sample (r_s1_delay),
        .gain   (r_s1_mix_gain),
        .scaled (w_s2_mix_scaled)
    );

    assign w_fb_sat  = sat_add(sample_t'(r_s2_dry), wide_t'(w_s2_fb_scaled));
    assign w_wet_sat = sat_add(sample_t'(r_s2_dry), wide_t'(w_s2_mix_scaled));

    // The strobe defaults low so a held wet_out never re-issues a buffer write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fb_out     <= '0;
            r_wet_out    <= '0;
            r_fb_wr_en   <= 1'b0;
            r_wet_valid  <= 1'b0;
            r_clip_count <= '0;
        end else begin
            r_fb_wr_en <= 1'b0;
            if (w_advance) begin
                r_wet_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    r_fb_out   <= w_fb_sat[DATA_WIDTH-1:0];
                    r_wet_out  <= w_wet_sat[DATA_WIDTH-1:0];
                    r_fb_wr_en <= 1'b1;
                    if ((w_fb_sat[DATA_WIDTH] | w_wet_sat[DATA_WIDTH]) && (r_clip_count != '1)) begin
                        r_clip_count <= r_clip_count + 1'b1;
                    end
                end
            end
        end
    end

    assign fb_out     = r_fb_out;
    assign wet_out    = r_wet_out;
    assign fb_wr_en   = r_fb_wr_en;
    assign wet_valid  = r_wet_valid;
    assign clip_count = r_clip_count;

endmodule

`default_nettype wire

// File: tb/tb_echo_feedback_mixer.sv
// ============================================================================
//  Module      : tb_echo_feedback_mixer
//  Description : Self-checking bench for echo_feedback_mixer against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_echo_feedback_mixer;

    localparam int DW = 32;
    localparam int GW = 16;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic [DW-1:0] dry_in;
    logic          dry_valid;
    logic          dry_ready;
    logic [DW-1:0] delay_in;
    logic          delay_valid;
    logic [GW-1:0] fb_gain;
    logic [GW-1:0] mix_gain;
    logic [DW-1:0] fb_out;
    logic          fb_wr_en;
    logic [DW-1:0] wet_out;
    logic          wet_valid;
    logic          wet_ready;
    logic [CW-1:0] clip_count;

    int total;
    int passed;
    int cyc;
    int fb_pulses;
    int hold_viol;
    int stall_seen;
    int exp_clip;
    logic [DW-1:0] exp_fb[$];
    logic [DW-1:0] exp_wet[$];
    logic [DW-1:0] obs_fb[$];
    logic [DW-1:0] obs_wet[$];

    echo_feedback_mixer #(
        .DATA_WIDTH (DW),
        .GAIN_WIDTH (GW),
        .CLIP_CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dry_in      (dry_in),
        .dry_valid   (dry_valid),
        .dry_ready   (dry_ready),
        .delay_in    (delay_in),
        .delay_valid (delay_valid),
        .fb_gain     (fb_gain),
        .mix_gain    (mix_gain),
        .fb_out      (fb_out),
        .fb_wr_en    (fb_wr_en),
        .wet_out     (wet_out),
        .wet_valid   (wet_valid),
        .wet_ready   (wet_ready),
        .clip_count  (clip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: dry + round(delayed * gain), clamped to the sample range; bit DW flags a clip.
    function automatic logic [DW:0] ref_mix(input logic [DW-1:0] dry, input logic [DW-1:0] dly,
                                            input logic dv, input logic [GW-1:0] g);
        longint d;
        longint s;
        d = dv ? longint'($signed(dly)) : 64'sd0;
        s = longint'($signed(dry)) + ((d * longint'($signed(g)) + 64'sd16384) >>> 15);
        if (s > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
        if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, s[31:0]};
    endfunction

    // Observer: model on every accepted sample, record every strobe/transfer, watch held output.
    initial begin
        logic          prev_hold;
        logic [DW-1:0] prev_wet;
        logic [DW:0]   f;
        logic [DW:0]   w;
        prev_hold = 1'b0;
        prev_wet  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && (!wet_valid || wet_out !== prev_wet)) hold_viol++;
                prev_hold = wet_valid && !wet_ready;
                prev_wet  = wet_out;
                if (fb_wr_en) begin
                    fb_pulses++;
                    obs_fb.push_back(fb_out);
                end
                if (wet_valid && wet_ready) obs_wet.push_back(wet_out);
                if (dry_valid && !dry_ready) stall_seen++;
                if (dry_valid && dry_ready) begin
                    f = ref_mix(dry_in, delay_in, delay_valid, fb_gain);
                    w = ref_mix(dry_in, delay_in, delay_valid, mix_gain);
                    exp_fb.push_back(f[DW-1:0]);
                    exp_wet.push_back(w[DW-1:0]);
                    if (f[DW] || w[DW]) exp_clip++;
                end
            end
        end
    end

    function automatic void clear_queues();
        exp_fb.delete();
        exp_wet.delete();
        obs_fb.delete();
        obs_wet.delete();
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] dl, input logic dv,
                        input logic [GW-1:0] fg, input logic [GW-1:0] mg);
        int   guard;
        logic ok;
        dry_in      = d;
        delay_in    = dl;
        delay_valid = dv;
        fb_gain     = fg;
        mix_gain    = mg;
        dry_valid   = 1'b1;
        guard       = 0;
        ok          = 1'b0;
        while (!ok && guard < 200) begin
            @(negedge clk);
            ok = dry_ready;
            @(posedge clk);
            #2;
            guard++;
        end
        dry_valid = 1'b0;
        if (!ok) begin
            total++;
            $display("FAIL send_timeout: dry_ready actual 0, required 1 within 200 cycles");
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((obs_wet.size() < exp_wet.size() || obs_fb.size() < exp_fb.size()) && guard < 300) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (guard >= 300) begin
            total++;
            $display("FAIL drain_timeout: outputs %0d, required %0d", obs_wet.size(), exp_wet.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total += 6;
        if (dry_ready !== 1'b0) $display("FAIL rst_dry_ready: actual %b required 0", dry_ready); else passed++;
        if (wet_valid !== 1'b0) $display("FAIL rst_wet_valid: actual %b required 0", wet_valid); else passed++;
        if (fb_wr_en !== 1'b0) $display("FAIL rst_fb_wr_en: actual %b required 0", fb_wr_en); else passed++;
        if (clip_count !== '0) $display("FAIL rst_clip_count: actual %0d required 0", clip_count); else passed++;
        if (fb_out !== '0) $display("FAIL rst_fb_out: actual %h required 0", fb_out); else passed++;
        if (wet_out !== '0) $display("FAIL rst_wet_out: actual %h required 0", wet_out); else passed++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        // Two saturating samples in flight, then reset: nothing of them may emerge.
        clear_queues();
        fb_pulses = 0;
        send(32'h7FFF_FF00, 32'h7FFF_FF00, 1'b1, 16'h7FFF, 16'h7FFF);
        send(32'h7FFF_FF00, 32'h7FFF_FF00, 1'b1, 16'h7FFF, 16'h7FFF);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (dry_ready !== 1'b0) $display("FAIL rst_mid_dry_ready: actual %b required 0", dry_ready); else passed++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_queues();
        exp_clip = 0;
        repeat (6) @(posedge clk);
        #2;
        total += 4;
        if (fb_pulses !== 0) $display("FAIL rst_mid_strobes: actual %0d required 0", fb_pulses); else passed++;
        if (wet_valid !== 1'b0) $display("FAIL rst_mid_wet_valid: actual %b required 0", wet_valid); else passed++;
        if (clip_count !== '0) $display("FAIL rst_mid_clip: actual %0d required 0", clip_count); else passed++;
        if (obs_wet.size() !== 0) $display("FAIL rst_mid_outputs: actual %0d required 0", obs_wet.size()); else passed++;
    endtask

    task automatic test_basic_mix();
        clear_queues();
        fb_pulses = 0;
        send(32'd1000, 32'd2000, 1'b1, 16'h4000, 16'h2000);
        @(negedge clk);
        total++;
        if (wet_valid !== 1'b0) $display("FAIL lat_n1_wet_valid: actual %b required 0", wet_valid); else passed++;
        @(negedge clk);
        total++;
        if (wet_valid !== 1'b0) $display("FAIL lat_n2_wet_valid: actual %b required 0", wet_valid); else passed++;
        @(negedge clk);
        total += 4;
        if (wet_valid !== 1'b1) $display("FAIL lat_n3_wet_valid: actual %b required 1", wet_valid); else passed++;
        if (fb_wr_en !== 1'b1) $display("FAIL lat_n3_fb_wr_en: actual %b required 1", fb_wr_en); else passed++;
        if (fb_out !== 32'd2000) $display("FAIL basic_fb_out: actual %0d required 2000", fb_out); else passed++;
        if (wet_out !== 32'd1500) $display("FAIL basic_wet_out: actual %0d required 1500", wet_out); else passed++;
        @(negedge clk);
        total += 2;
        if (fb_wr_en !== 1'b0) $display("FAIL basic_strobe_width: actual %b required 0", fb_wr_en); else passed++;
        if (fb_pulses !== 1) $display("FAIL basic_strobe_count: actual %0d required 1", fb_pulses); else passed++;
        @(posedge clk);
        #2;
    endtask

    task automatic test_delay_invalid();
        logic [DW-1:0] a_fb;
        logic [DW-1:0] a_wet;
        clear_queues();
        send(32'd1000, 32'd5000, 1'b0, 16'h4000, 16'h2000);
        drain();
        a_fb  = (obs_fb.size() > 0) ? obs_fb[0] : 'x;
        a_wet = (obs_wet.size() > 0) ? obs_wet[0] : 'x;
        total += 2;
        if (a_fb !== 32'd1000) $display("FAIL nodelay_fb_out: actual %0d required 1000", a_fb); else passed++;
        if (a_wet !== 32'd1000) $display("FAIL nodelay_wet_out: actual %0d required 1000", a_wet); else passed++;
    endtask

    task automatic test_saturation();
        logic [CW-1:0] c0;
        logic [DW-1:0] req_fb[4];
        logic [DW-1:0] req_wet[4];
        logic [DW-1:0] a;
        req_fb  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8001_0000};
        req_wet = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};
        clear_queues();
        c0 = clip_count;
        send(32'h7FFF_FF00, 32'h7FFF_FF00, 1'b1, 16'h7FFF, 16'h7FFF);
        send(32'h0000_0000, 32'h8000_0000, 1'b1, 16'h8000, 16'h8000);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 16'h7FFF, 16'h7FFF);
        send(32'h0000_0000, 32'h8000_0000, 1'b1, 16'h7FFF, 16'h4000);
        drain();
        for (int i = 0; i < 4; i++) begin
            a = (obs_fb.size() > i) ? obs_fb[i] : 'x;
            total++;
            if (a !== req_fb[i]) $display("FAIL sat_fb[%0d]: actual %h required %h", i, a, req_fb[i]); else passed++;
            a = (obs_wet.size() > i) ? obs_wet[i] : 'x;
            total++;
            if (a !== req_wet[i]) $display("FAIL sat_wet[%0d]: actual %h required %h", i, a, req_wet[i]); else passed++;
        end
        total++;
        if (clip_count !== c0 + 3'd3) $display("FAIL sat_clip_count: actual %0d required %0d", clip_count, c0 + 3'd3); else passed++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a;
        clear_queues();
        fb_pulses  = 0;
        stall_seen = 0;
        hold_viol  = 0;
        fork
            for (int i = 0; i < 8; i++) begin
                send($urandom, $urandom, 1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                wet_ready = 1'b0;
                repeat (4) @(posedge clk);
                #2;
                wet_ready = 1'b1;
            end
        join
        drain();
        total += 5;
        if (stall_seen == 0) $display("FAIL bp_dry_ready_drop: stalled cycles actual 0, required >0"); else passed++;
        if (hold_viol !== 0) $display("FAIL bp_wet_hold: changes actual %0d required 0", hold_viol); else passed++;
        if (fb_pulses !== 8) $display("FAIL bp_strobes: actual %0d required 8", fb_pulses); else passed++;
        if (obs_wet.size() !== 8) $display("FAIL bp_wet_count: actual %0d required 8", obs_wet.size()); else passed++;
        if (clip_count !== CW'(exp_clip)) $display("FAIL bp_clip_count: actual %0d required %0d", clip_count, exp_clip); else passed++;
        for (int i = 0; i < exp_wet.size(); i++) begin
            a = (obs_wet.size() > i) ? obs_wet[i] : 'x;
            total++;
            if (a !== exp_wet[i]) $display("FAIL bp_wet[%0d]: actual %h required %h", i, a, exp_wet[i]); else passed++;
            a = (obs_fb.size() > i) ? obs_fb[i] : 'x;
            total++;
            if (a !== exp_fb[i]) $display("FAIL bp_fb[%0d]: actual %h required %h", i, a, exp_fb[i]); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a;
        int            c_start;
        clear_queues();
        fb_pulses = 0;
        hold_viol = 0;
        wet_ready = 1'b1;
        c_start   = cyc;
        for (int i = 0; i < 100; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end
        total++;
        if (cyc - c_start !== 100) $display("FAIL b2b_throughput: cycles actual %0d required 100", cyc - c_start); else passed++;
        drain();
        total += 3;
        if (fb_pulses !== 100) $display("FAIL b2b_strobes: actual %0d required 100", fb_pulses); else passed++;
        if (obs_wet.size() !== 100) $display("FAIL b2b_wet_count: actual %0d required 100", obs_wet.size()); else passed++;
        if (clip_count !== CW'(exp_clip)) $display("FAIL b2b_clip_count: actual %0d required %0d", clip_count, exp_clip); else passed++;
        for (int i = 0; i < exp_wet.size(); i++) begin
            a = (obs_wet.size() > i) ? obs_wet[i] : 'x;
            total++;
            if (a !== exp_wet[i]) $display("FAIL b2b_wet[%0d]: actual %h required %h", i, a, exp_wet[i]); else passed++;
            a = (obs_fb.size() > i) ? obs_fb[i] : 'x;
            total++;
            if (a !== exp_fb[i]) $display("FAIL b2b_fb[%0d]: actual %h required %h", i, a, exp_fb[i]); else passed++;
        end
    endtask

    initial begin
        total       = 0;
        passed      = 0;
        cyc         = 0;
        fb_pulses   = 0;
        hold_viol   = 0;
        stall_seen  = 0;
        exp_clip    = 0;
        rst         = 1'b1;
        dry_in      = '0;
        dry_valid   = 1'b0;
        delay_in    = '0;
        delay_valid = 1'b0;
        fb_gain     = '0;
        mix_gain    = '0;
        wet_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        test_reset();
        test_basic_mix();
        test_delay_invalid();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
